// File: rtl/cfg_bitstream_loader_if.sv
// Word-stream and configuration-write bundle for cfg_bitstream_loader.
// master: word source / write-port observer side; slave: the loader.
interface cfg_bitstream_loader_if #(
  parameter int IDX_W = 5
);
  logic [31:0]      in_word;
  logic             in_valid;
  logic             in_ready;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_index;
  logic [32:0]      cfg_data;

  modport master (
    output in_word, in_valid,
    input  in_ready, cfg_we, cfg_index, cfg_data
  );

  modport slave (
    input  in_word, in_valid,
    output in_ready, cfg_we, cfg_index, cfg_data
  );
endinterface

// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader: streams 32-bit configuration words, skips the
// switch-box header, and writes one 33-bit word per target in ascending
// index order. Optional trailing XOR checksum: CFG_LOADER_CHECKSUM_EN.
module cfg_bitstream_loader #(
  parameter int NUM_TARGETS  = 20,
  parameter int HEADER_WORDS = 3,
  parameter int IDX_W        = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  cfg_bitstream_loader_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int HDR_W      = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1;
  localparam int HDR_LAST_I = (HEADER_WORDS > 0) ? HEADER_WORDS - 1 : 0;
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_LAST_I[HDR_W-1:0];
  localparam logic [IDX_W-1:0] TGT_LAST = IDX_W'(NUM_TARGETS - 1);

`ifdef CFG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOW, S_HIGH, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOW, S_HIGH, S_DONE
  } state_t;
`endif

  state_t           state;
  logic [HDR_W-1:0] hdr_cnt;
  logic [IDX_W-1:0] tgt_cnt;
  logic [31:0]      lo_reg;
  logic             xfer;

  assign xfer = bus.in_valid & bus.in_ready;

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [31:0] acc;
  logic        err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Load sequencer: header skip, low/high word pairing, registered write strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b0;
      bus.cfg_we    <= 1'b0;
      bus.cfg_index <= '0;
      bus.cfg_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hdr_cnt       <= '0;
      tgt_cnt       <= '0;
      lo_reg        <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
      acc           <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      bus.cfg_we <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      if (xfer) acc <= acc ^ bus.in_word;
`endif
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy         <= 1'b1;
            done         <= 1'b0;
            hdr_cnt      <= '0;
            tgt_cnt      <= '0;
            bus.in_ready <= 1'b1;
            state        <= (HEADER_WORDS > 0) ? S_HEADER : S_LOW;
`ifdef CFG_LOADER_CHECKSUM_EN
            acc          <= '0;
            err_q        <= 1'b0;
`endif
          end
        end
        S_HEADER: begin
          if (xfer) begin
            if (hdr_cnt == HDR_LAST) state <= S_LOW;
            else                     hdr_cnt <= hdr_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (xfer) begin
            lo_reg <= bus.in_word;
            state  <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (xfer) begin
            bus.cfg_data  <= {bus.in_word[0], lo_reg};
            bus.cfg_index <= tgt_cnt;
            bus.cfg_we    <= 1'b1;
            if (tgt_cnt == TGT_LAST) begin
`ifdef CFG_LOADER_CHECKSUM_EN
              state        <= S_CHECK;
`else
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
`endif
            end else begin
              tgt_cnt <= tgt_cnt + 1'b1;
              state   <= S_LOW;
            end
          end
        end
`ifdef CFG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            // acc still holds the XOR of every word before this one
            err_q        <= (bus.in_word != acc);
            done         <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
            state        <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
